// File: rtl/pq_arbiter_if.sv
// Requester, priority-queue and status signals of the shared priority-queue arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface pq_arbiter_if #(
  parameter int N_REQ       = 4,
  parameter int QUEUE_DEPTH = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int ID_WIDTH    = $clog2(QUEUE_DEPTH) + 1
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [N_REQ-1:0]            req_push_i;
  logic [N_REQ-1:0]            req_pop_i;
  logic [N_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [N_REQ*ID_WIDTH-1:0]   req_id_i;
  logic [N_REQ-1:0]            req_gnt_o;
  logic [N_REQ-1:0]            rsp_valid_o;
  logic [DATA_WIDTH-1:0]       rsp_data_o;
  logic [ID_WIDTH-1:0]         rsp_id_o;
  logic                        pq_push_o;
  logic                        pq_pop_o;
  logic [DATA_WIDTH-1:0]       pq_data_o;
  logic [ID_WIDTH-1:0]         pq_id_o;
  logic                        pq_rdy_i;
  logic                        pq_rsp_valid_i;
  logic [DATA_WIDTH-1:0]       pq_rsp_data_i;
  logic [ID_WIDTH-1:0]         pq_rsp_id_i;
  logic [CNT_W-1:0]            cnt_o;
  logic                        full_o;
  logic                        empty_o;
  logic                        spurious_o;

  modport slave (
    input  req_push_i, req_pop_i, req_data_i, req_id_i,
    input  pq_rdy_i, pq_rsp_valid_i, pq_rsp_data_i, pq_rsp_id_i,
    output req_gnt_o, rsp_valid_o, rsp_data_o, rsp_id_o,
    output pq_push_o, pq_pop_o, pq_data_o, pq_id_o,
    output cnt_o, full_o, empty_o, spurious_o
  );

  modport master (
    output req_push_i, req_pop_i, req_data_i, req_id_i,
    output pq_rdy_i, pq_rsp_valid_i, pq_rsp_data_i, pq_rsp_id_i,
    input  req_gnt_o, rsp_valid_o, rsp_data_o, rsp_id_o,
    input  pq_push_o, pq_pop_o, pq_data_o, pq_id_o,
    input  cnt_o, full_o, empty_o, spurious_o
  );
endinterface

// File: rtl/pq_arbiter.sv
// Round-robin arbiter sharing one priority queue between N_REQ requesters; tracks
// occupancy and routes pop responses back through an in-order tag FIFO.
module pq_arbiter #(
  parameter int N_REQ       = 4,
  parameter int QUEUE_DEPTH = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int ID_WIDTH    = $clog2(QUEUE_DEPTH) + 1,
  parameter int MAX_OUTST   = 4
) (
  input logic         clk_i,
  input logic         rst_i,
  pq_arbiter_if.slave bus
);
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam int TAG_AW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [IDX_W-1:0]      rr_ptr;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      tag_mem [MAX_OUTST];
  logic [TAG_AW-1:0]     tag_wr, tag_rd;
  logic [TAG_AW:0]       tag_cnt;
  logic                  tag_full, tag_empty;
  logic [IDX_W-1:0]      tag_head;

  logic [N_REQ-1:0]      is_push, is_pop, elig, gnt;
  logic                  push_ok, pop_ok, gnt_any, gnt_push, gnt_pop, rsp_hit;
  logic [IDX_W-1:0]      gnt_idx, cand;

  logic                  pq_push_p1, pq_pop_p1, spurious_p1;
  logic [DATA_WIDTH-1:0] pq_data_p1, rsp_data_p1;
  logic [ID_WIDTH-1:0]   pq_id_p1, rsp_id_p1;
  logic [N_REQ-1:0]      rsp_valid_p1;

  assign tag_full  = (tag_cnt == (TAG_AW+1)'(MAX_OUTST));
  assign tag_empty = (tag_cnt == '0);
  assign tag_head  = tag_mem[tag_rd];
  assign rsp_hit   = bus.pq_rsp_valid_i && !tag_empty;

  // Push wins over pop per requester; eligibility gated by occupancy, tag space and pq_rdy_i.
  always_comb begin
    is_push = bus.req_push_i;
    is_pop  = ~bus.req_push_i & bus.req_pop_i;
    push_ok = (cnt != CNT_W'(QUEUE_DEPTH));
    pop_ok  = (cnt != '0) && !tag_full;
    elig    = {N_REQ{bus.pq_rdy_i}} &
              ((is_push & {N_REQ{push_ok}}) | (is_pop & {N_REQ{pop_ok}}));
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt      = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
    gnt_push = gnt_any && is_push[gnt_idx];
    gnt_pop  = gnt_any && is_pop[gnt_idx];
  end

  assign bus.req_gnt_o = gnt;

  // Stage p1: registered queue commands, occupancy, tag FIFO pointers and routed responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr       <= '0;
      cnt          <= '0;
      tag_wr       <= '0;
      tag_rd       <= '0;
      tag_cnt      <= '0;
      pq_push_p1   <= 1'b0;
      pq_pop_p1    <= 1'b0;
      pq_data_p1   <= '0;
      pq_id_p1     <= '0;
      rsp_valid_p1 <= '0;
      rsp_data_p1  <= '0;
      rsp_id_p1    <= '0;
      spurious_p1  <= 1'b0;
    end else begin
      if (gnt_any)
        rr_ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

      case ({gnt_push, gnt_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase

      if (gnt_pop) tag_wr <= tag_wr + TAG_AW'(1);
      if (rsp_hit) tag_rd <= tag_rd + TAG_AW'(1);
      case ({gnt_pop, rsp_hit})
        2'b10:   tag_cnt <= tag_cnt + (TAG_AW+1)'(1);
        2'b01:   tag_cnt <= tag_cnt - (TAG_AW+1)'(1);
        default: tag_cnt <= tag_cnt;
      endcase

      pq_push_p1 <= gnt_push;
      pq_pop_p1  <= gnt_pop;
      if (gnt_push) begin
        pq_data_p1 <= bus.req_data_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        pq_id_p1   <= bus.req_id_i[gnt_idx*ID_WIDTH +: ID_WIDTH];
      end

      rsp_valid_p1 <= rsp_hit ? (N_REQ'(1) << tag_head) : '0;
      spurious_p1  <= bus.pq_rsp_valid_i && tag_empty;
      if (rsp_hit) begin
        rsp_data_p1 <= bus.pq_rsp_data_i;
        rsp_id_p1   <= bus.pq_rsp_id_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt_pop) tag_mem[tag_wr] <= gnt_idx;
  end

  assign bus.pq_push_o   = pq_push_p1;
  assign bus.pq_pop_o    = pq_pop_p1;
  assign bus.pq_data_o   = pq_data_p1;
  assign bus.pq_id_o     = pq_id_p1;
  assign bus.rsp_valid_o = rsp_valid_p1;
  assign bus.rsp_data_o  = rsp_data_p1;
  assign bus.rsp_id_o    = rsp_id_p1;
  assign bus.spurious_o  = spurious_p1;
  assign bus.cnt_o       = cnt;
  assign bus.full_o      = (cnt == CNT_W'(QUEUE_DEPTH));
  assign bus.empty_o     = (cnt == '0);
endmodule
